// File: rtl/decoder_scan_pkg.sv
// decoder_scan_pkg: shared types and helpers for the scanning decoder.
//   state_t    : FSM encodings ST_DIRECT / ST_SCAN_ON / ST_SCAN_BLANK.
//   onehot_n() : active-low one-hot of idx, all ones when idx >= valid_lim.
//   clog2_u()  : ceiling log2, used to size the blank counter.
package decoder_scan_pkg;

  typedef enum logic [1:0] {
    ST_DIRECT     = 2'd0,
    ST_SCAN_ON    = 2'd1,
    ST_SCAN_BLANK = 2'd2
  } state_t;

  // Widest output vector the helper can produce; callers size-cast down.
  localparam int unsigned MAX_OUT_W = 256;

  function automatic logic [MAX_OUT_W-1:0] onehot_n(input int unsigned idx,
                                                     input int unsigned valid_lim);
    logic [MAX_OUT_W-1:0] v;
    v = '1;
    if (idx < valid_lim) v = ~(MAX_OUT_W'(1) << idx);
    return v;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_timer.sv
// decoder_scan_timer: dwell down-counter and (optionally) blank down-counter.
// Build option: DECODER_SCAN_BLANK_EN adds the blank counter and its ports.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   en               : count enable; low freezes both counters
//   clr              : clear both counters to 0 (when en)
//   dwell_load/_val  : load dwell counter
//   dwell_done       : dwell counter is 0
//   blank_load/_val  : load blank counter (blank build only)
//   blank_done       : blank counter is 0 (blank build only)
module decoder_scan_timer #(
  parameter int DWELL_W = 16
`ifdef DECODER_SCAN_BLANK_EN
  , parameter int BLANK_W = 1
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic               dwell_load,
  input  logic [DWELL_W-1:0] dwell_val,
`ifdef DECODER_SCAN_BLANK_EN
  input  logic               blank_load,
  input  logic [BLANK_W-1:0] blank_val,
  output logic               blank_done,
`endif
  output logic               dwell_done
);

  logic [DWELL_W-1:0] dwell_cnt_reg;

  // Counters idle at zero, so free-running decrement-while-nonzero is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt_reg <= '0;
    end else if (en) begin
      if (clr)                      dwell_cnt_reg <= '0;
      else if (dwell_load)          dwell_cnt_reg <= dwell_val;
      else if (dwell_cnt_reg != '0) dwell_cnt_reg <= dwell_cnt_reg - 1'b1;
    end
  end

  assign dwell_done = (dwell_cnt_reg == '0);

`ifdef DECODER_SCAN_BLANK_EN
  logic [BLANK_W-1:0] blank_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_cnt_reg <= '0;
    end else if (en) begin
      if (clr)                      blank_cnt_reg <= '0;
      else if (blank_load)          blank_cnt_reg <= blank_val;
      else if (blank_cnt_reg != '0) blank_cnt_reg <= blank_cnt_reg - 1'b1;
    end
  end

  assign blank_done = (blank_cnt_reg == '0);
`endif

endmodule

// File: rtl/decoder_scan.sv
// decoder_scan: SEL_W -> 2**SEL_W active-low decoder with 74x138 enable
// gating, registered outputs, and an autonomous scan sequencer.
// Build option: DECODER_SCAN_BLANK_EN inserts BLANK_CYC all-high cycles
// after every scan step.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   en[2:0]  : G1 (en[0], high), G2A/G2B (en[1]/en[2], low)
//   mode     : 0 direct decode, 1 scan
//   sel      : direct-mode select
//   dwell    : scan step length minus one
//   y        : decoded outputs, active low, registered
//   cur_idx  : index currently driven
//   wrap     : one-cycle pulse when scan index returns to 0
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter int NUM_OUT   = 8,
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] y,
  output logic [SEL_W-1:0]    cur_idx,
  output logic                wrap
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  state_t           state_reg, state_next;
  logic [SEL_W-1:0] idx_reg, idx_next;
  logic [OUT_W-1:0] y_reg, y_next;
  logic [SEL_W-1:0] cur_idx_reg, cur_idx_next;
  logic             wrap_reg, wrap_next;

  logic             act;
  logic             tmr_clr;
  logic             dwell_load;
  logic             dwell_done;
  logic [SEL_W-1:0] idx_adv;
  logic [OUT_W-1:0] oh_sel, oh_idx, oh_adv;

  assign act     = en[0] & ~en[1] & ~en[2];
  assign idx_adv = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
  assign oh_sel  = OUT_W'(onehot_n(32'(sel), NUM_OUT));
  assign oh_idx  = OUT_W'(onehot_n(32'(idx_reg), NUM_OUT));
  assign oh_adv  = OUT_W'(onehot_n(32'(idx_adv), NUM_OUT));

`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLANK_W_RAW = int'(clog2_u(BLANK_CYC));
  localparam int BLANK_W     = (BLANK_W_RAW < 1) ? 1 : BLANK_W_RAW;
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYC - 1);

  logic blank_load;
  logic blank_done;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_DIRECT;
      idx_reg     <= '0;
      y_reg       <= '1;
      cur_idx_reg <= '0;
      wrap_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      y_reg       <= y_next;
      cur_idx_reg <= cur_idx_next;
      wrap_reg    <= wrap_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    y_next       = y_reg;
    cur_idx_next = cur_idx_reg;
    wrap_next    = 1'b0;
    tmr_clr      = 1'b0;
    dwell_load   = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    blank_load   = 1'b0;
`endif

    if (!act) begin
      // Disabled: blank the outputs, freeze everything else.
      y_next = '1;
    end else begin
      case (state_reg)
        ST_DIRECT: begin
          if (mode) begin
            // Entry edge already shows index 0 and counts as the first dwell cycle.
            state_next   = ST_SCAN_ON;
            idx_next     = '0;
            cur_idx_next = '0;
            y_next       = OUT_W'(onehot_n(32'd0, NUM_OUT));
            dwell_load   = 1'b1;
          end else begin
            y_next       = oh_sel;
            cur_idx_next = sel;
          end
        end

        ST_SCAN_ON: begin
          if (!mode) begin
            state_next   = ST_DIRECT;
            idx_next     = '0;
            tmr_clr      = 1'b1;
            y_next       = oh_sel;
            cur_idx_next = sel;
          end else if (dwell_done) begin
`ifdef DECODER_SCAN_BLANK_EN
            state_next   = ST_SCAN_BLANK;
            y_next       = '1;
            blank_load   = 1'b1;
`else
            idx_next     = idx_adv;
            cur_idx_next = idx_adv;
            y_next       = oh_adv;
            wrap_next    = (idx_reg == LAST_IDX);
            dwell_load   = 1'b1;
`endif
          end else begin
            // Re-derived every cycle so a resume after a freeze redraws the line.
            y_next = oh_idx;
          end
        end

`ifdef DECODER_SCAN_BLANK_EN
        ST_SCAN_BLANK: begin
          if (!mode) begin
            state_next   = ST_DIRECT;
            idx_next     = '0;
            tmr_clr      = 1'b1;
            y_next       = oh_sel;
            cur_idx_next = sel;
          end else if (blank_done) begin
            state_next   = ST_SCAN_ON;
            idx_next     = idx_adv;
            cur_idx_next = idx_adv;
            y_next       = oh_adv;
            wrap_next    = (idx_reg == LAST_IDX);
            dwell_load   = 1'b1;
          end else begin
            y_next = '1;
          end
        end
`endif

        default: begin
          state_next = ST_DIRECT;
          y_next     = '1;
        end
      endcase
    end
  end

  decoder_scan_timer #(
    .DWELL_W (DWELL_W)
`ifdef DECODER_SCAN_BLANK_EN
    , .BLANK_W (BLANK_W)
`endif
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (act),
    .clr        (tmr_clr),
    .dwell_load (dwell_load),
    .dwell_val  (dwell),
`ifdef DECODER_SCAN_BLANK_EN
    .blank_load (blank_load),
    .blank_val  (BLANK_LOAD),
    .blank_done (blank_done),
`endif
    .dwell_done (dwell_done)
  );

  assign y       = y_reg;
  assign cur_idx = cur_idx_reg;
  assign wrap    = wrap_reg;

endmodule

// File: tb/tb_decoder_scan.sv
// tb_decoder_scan: directed self-checking bench for decoder_scan.
// Four instances share stimulus and differ only in NUM_OUT (8, 6, 4, 1).
module tb_decoder_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  en = 3'b000;
  logic        mode = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] dwell = 16'd0;

  logic [7:0] y8, y6, y4, y1;
  logic [2:0] ci8, ci6, ci4, ci1;
  logic       w8, w6, w4, w1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int P    = 20;  // NUM_OUT=4 scan period
  localparam int STEP = 5;   // dwell+1 active + 2 blank
  localparam int NR   = 8;
`else
  localparam int P    = 12;
  localparam int STEP = 3;
  localparam int NR   = 6;
`endif

  always #5 clk = ~clk;

  decoder_scan #(.NUM_OUT(8)) dut8 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .y(y8), .cur_idx(ci8), .wrap(w8));
  decoder_scan #(.NUM_OUT(6)) dut6 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .y(y6), .cur_idx(ci6), .wrap(w6));
  decoder_scan #(.NUM_OUT(4)) dut4 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .y(y4), .cur_idx(ci4), .wrap(w4));
  decoder_scan #(.NUM_OUT(1)) dut1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .dwell(dwell), .y(y1), .cur_idx(ci1), .wrap(w1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] e;
  logic [7:0] exp_r [0:7];
  int         k;
  int         found;

  initial begin
`ifdef DECODER_SCAN_BLANK_EN
    exp_r[0] = 8'hFE; exp_r[1] = 8'hFE; exp_r[2] = 8'hFF; exp_r[3] = 8'hFF;
    exp_r[4] = 8'hFD; exp_r[5] = 8'hFF; exp_r[6] = 8'hFF; exp_r[7] = 8'hFB;
`else
    exp_r[0] = 8'hFE; exp_r[1] = 8'hFE; exp_r[2] = 8'hFD; exp_r[3] = 8'hFB;
    exp_r[4] = 8'hF7; exp_r[5] = 8'hFE; exp_r[6] = 8'hFF; exp_r[7] = 8'hFF;
`endif

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b1;
    #1;
    check("rst_y8", y8, 8'hFF);
    check("rst_ci8", ci8, 3'd0);
    check("rst_w8", w8, 1'b0);
    check("rst_y4", y4, 8'hFF);
    step();
    step();
    rst = 1'b0; en = 3'b001; mode = 1'b0; sel = 3'd3;
    step();
    check("direct_sel3_y", y8, 8'hF7);
    check("direct_sel3_ci", ci8, 3'd3);

    // Enable gating.
    en = 3'b011; sel = 3'd5;
    step();
    check("g2a_off_y", y8, 8'hFF);
    check("g2a_off_w", w8, 1'b0);
    en = 3'b001;
    step();
    check("en_sel5_y", y8, 8'hDF);
    check("en_sel5_ci", ci8, 3'd5);
    en = 3'b000;
    step();
    check("g1_off_y", y8, 8'hFF);
    check("g1_off_ci", ci8, 3'd5);

    // Out-of-range select on NUM_OUT=6, top index on NUM_OUT=8.
    en = 3'b001; sel = 3'd7;
    step();
    check("oor_y6", y6, 8'hFF);
    check("oor_ci6", ci6, 3'd7);
    check("sel7_y8", y8, 8'h7F);
    check("oor_y4", y4, 8'hFF);

    // Scan entry, dwell = 2.
    mode = 1'b1; dwell = 16'd2;
    step();
    check("scan_k0_y4", y4, 8'hFE);
    check("scan_k0_ci4", ci4, 3'd0);
    check("scan_k0_w4", w4, 1'b0);
    check("scan_k0_w1", w1, 1'b0);

    for (k = 1; k <= P; k++) begin
      step();
      e = ((k % STEP) < 3) ? ~(8'h01 << ((k / STEP) % 4)) : 8'hFF;
      check($sformatf("scan4_k%0d_y", k), y4, e);
      check($sformatf("scan4_k%0d_w", k), w4, (k % P) == 0);
      e = ((k % STEP) < 3) ? ~(8'h01 << ((k / STEP) % 8)) : 8'hFF;
      check($sformatf("scan8_k%0d_y", k), y8, e);
      check($sformatf("scan8_k%0d_w", k), w8, 1'b0);
      e = ((k % STEP) < 3) ? 8'hFE : 8'hFF;
      check($sformatf("scan1_k%0d_y", k), y1, e);
      check($sformatf("scan1_k%0d_w", k), w1, (k % STEP) == 0);
    end

    // Freeze one cycle into the idx-0 step, then resume with 2 dwell cycles left.
    en = 3'b000;
    for (int f = 0; f < 5; f++) begin
      step();
      check($sformatf("freeze%0d_y", f), y4, 8'hFF);
      check($sformatf("freeze%0d_w", f), w4, 1'b0);
      check($sformatf("freeze%0d_ci", f), ci4, 3'd0);
    end
    en = 3'b001;
    step();
    check("resume0_y", y4, 8'hFE);
    step();
    check("resume1_y", y4, 8'hFE);
    step();
`ifdef DECODER_SCAN_BLANK_EN
    check("resume2_y", y4, 8'hFF);
`else
    check("resume2_y", y4, 8'hFD);
`endif

    // Run until NUM_OUT=4 instance drives index 2, then drop to direct mode.
    found = 0;
    for (int b = 0; b < 40 && found == 0; b++) begin
      step();
      if (y4 == 8'hFB) found = 1;
    end
    check("find_idx2", found, 1);
    check("idx2_ci4", ci4, 3'd2);
    mode = 1'b0; sel = 3'd1;
    step();
    check("to_direct_y4", y4, 8'hFD);
    check("to_direct_ci4", ci4, 3'd1);
    check("to_direct_y8", y8, 8'hFD);
    check("to_direct_w4", w4, 1'b0);

    // Restart scan at 0; dwell change mid-step takes effect next step.
    mode = 1'b1;
    step();
    check("restart_y4", y4, 8'hFE);
    check("restart_ci4", ci4, 3'd0);
    dwell = 16'd0;
    for (int r = 0; r < NR; r++) begin
      step();
      check($sformatf("restart_r%0d_y", r), y4, exp_r[r]);
    end

    // Asynchronous reset mid-cycle while scanning.
    #2 rst = 1'b1;
    #1;
    check("rst2_y4", y4, 8'hFF);
    check("rst2_ci4", ci4, 3'd0);
    check("rst2_w4", w4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
